// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register.
// Issues word fetches over a valid/ready channel, tracks in-flight addresses
// in a tag queue, buffers returned words with their PCs in a FIFO and flushes
// on a redirect, discarding responses that were already in flight.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, a response
// arriving while the FIFO is empty is presented to decode in the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    fifo_pc_q   [DEPTH];
    logic [31:0]    fifo_inst_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    tag_q [MAX_OUT];
    logic [TW-1:0]  tag_rd_q, tag_rd_d;
    logic [TW-1:0]  tag_wr_q, tag_wr_d;
    logic [OW-1:0]  out_q, out_d;
    logic [OW-1:0]  drop_q, drop_d;

    logic        rsp_ok;
    logic        fifo_empty;
    logic        credit_ok;
    logic        req_fire;
    logic        run_rsp;
    logic        byp_hit;
    logic        fifo_push;
    logic        fifo_pop;
    logic [31:0] head_pc;
    logic [31:0] head_inst;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        if (32'(p) == MAX_OUT - 1) return '0;
        return p + TW'(1);
    endfunction

    // Request/response handshakes and credit accounting.
    always_comb begin
        rsp_ok         = imem_rsp_valid && (out_q != '0);
        fifo_empty     = (count_q == '0);
        credit_ok      = ((32'(count_q) + 32'(out_q)) < DEPTH) && (32'(out_q) < MAX_OUT);
        // Gated by rst_n so the request channel is idle while reset is held.
        imem_req_valid = rst_n && (state_q == ST_RUN) && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        run_rsp        = (state_q == ST_RUN) && !redirect_valid && rsp_ok;
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    // A response into an empty FIFO goes straight to decode.
    always_comb byp_hit = run_rsp && fifo_empty;
`else
    // Every response is registered in the FIFO first.
    always_comb byp_hit = 1'b0;
`endif

    // Decode-side head selection, pop and push decisions.
    always_comb begin
        head_pc   = fifo_pc_q[rd_ptr_q];
        head_inst = fifo_inst_q[rd_ptr_q];
        if (byp_hit) begin
            head_pc   = tag_q[tag_rd_q];
            head_inst = imem_rsp_data;
        end
        if_valid  = !redirect_valid && (!fifo_empty || byp_hit);
        if_pc     = if_valid ? head_pc : '0;
        if_inst   = if_valid ? head_inst : NOP;
        fifo_pop  = if_valid && id_ready && !fifo_empty;
        fifo_push = run_rsp && !(byp_hit && id_ready);
    end

    // Next-state logic: redirect overrides everything, FLUSH drains stale responses.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        drop_d     = drop_q;
        out_d      = out_q + OW'(req_fire) - OW'(rsp_ok);

        if (redirect_valid) begin
            // Words still in flight after this cycle must be discarded.
            fetch_pc_d = redirect_pc & ~32'h3;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
            drop_d     = out_d;
            state_d    = (out_d != '0) ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_FLUSH) begin
            if (rsp_ok) begin
                drop_d = drop_q - OW'(1);
                if (drop_q == OW'(1)) state_d = ST_RUN;
            end
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tag_wr_d   = tag_next(tag_wr_q);
            end
            if (rsp_ok) tag_rd_d = tag_next(tag_rd_q);
            if (fifo_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (fifo_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    // Tag and instruction storage; contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (req_fire) tag_q[tag_wr_q] <= fetch_pc_q;
        if (fifo_push) begin
            fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
            fifo_inst_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (out_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed vector table from reset,
// hand-written redirect/reset/latency sequences, and a randomized run
// checked against a transaction-level memory and decode-stream model.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory/decode reference model.
    logic [31:0] pend[$];        // requests accepted by memory, oldest first
    int          stale;          // responses still to be discarded after a redirect
    int          held;           // words delivered to the DUT but not yet decoded
    int          consumed;
    logic [31:0] exp_fetch;      // next address the fetch stream must request
    logic [31:0] exp_dec;        // next PC decode must see
    bit          last_ifv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_00FF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        stale     = 0;
        held      = 0;
        exp_fetch = RESET_PC;
        exp_dec   = RESET_PC;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr",  imem_req_addr, RESET_PC);
        chk("rst_if_valid",  if_valid, 0);
        chk("rst_if_pc",     if_pc, 0);
        chk("rst_if_inst",   if_inst, NOP);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus; outputs are judged at the falling edge.
    task automatic step(input bit rdy, input bit rsp_en, input bit idr,
                        input bit redir, input logic [31:0] rpc);
        bit rsp, fire, take, credit;
        rsp = rsp_en && (pend.size() > 0);
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend[0]) : 32'hDEAD_BEEF;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(negedge clk);
        fire     = imem_req_valid && rdy;
        take     = if_valid && idr;
        last_ifv = if_valid;
        credit   = (held + pend.size() < DEPTH) && (pend.size() < MAX_OUT);
        if (!if_valid) chk("nop_when_idle", if_inst, NOP);
        if (redir) begin
            chk("redirect_no_issue", imem_req_valid, 0);
            chk("redirect_no_pop", if_valid, 0);
        end else if (stale > 0) begin
            chk("flush_no_issue", imem_req_valid, 0);
            chk("flush_no_output", if_valid, 0);
        end else begin
            chk("req_valid_rule", imem_req_valid, credit);
            chk("if_valid_rule", if_valid, (held > 0) || (BYP && rsp));
        end
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
        if (take) begin
            chk("dec_pc", if_pc, exp_dec);
            chk("dec_inst", if_inst, mem_word(exp_dec));
            exp_dec = exp_dec + 32'd4;
            consumed++;
        end
        if (fire) begin
            pend.push_back(imem_req_addr);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rsp) begin
            void'(pend.pop_front());
            if (!redir) begin
                if (stale > 0) stale--;
                else held++;
            end
        end
        if (take) held--;
        if (redir) begin
            stale     = pend.size();
            held      = 0;
            exp_fetch = rpc & ~32'h3;
            exp_dec   = rpc & ~32'h3;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_consumes(input int n, input string name);
        int c0;
        int k;
        c0 = consumed;
        k  = 0;
        while (consumed < c0 + n && k < 60) begin
            step(1, 1, 1, 0, '0);
            k++;
        end
        chk(name, consumed >= c0 + n, 1);
    endtask

    typedef struct {
        bit          idr;
        bit          rspv;
        logic [31:0] rsp_addr;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_ifv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        // Fill from reset with decode stalled, then release (memory always
        // ready, each response one cycle after its request).
        tbl[0]  = '{0, 0, 32'h00, 1, 32'h00, 0,   32'h00};
        tbl[1]  = '{0, 1, 32'h00, 1, 32'h04, BYP, 32'h00};
        tbl[2]  = '{0, 1, 32'h04, 1, 32'h08, 1,   32'h00};
        tbl[3]  = '{0, 1, 32'h08, 1, 32'h0C, 1,   32'h00};
        tbl[4]  = '{0, 1, 32'h0C, 0, 32'h10, 1,   32'h00};
        for (int i = 5; i < 10; i++) tbl[i] = '{0, 0, 32'h00, 0, 32'h10, 1, 32'h00};
        tbl[10] = '{1, 0, 32'h00, 0, 32'h10, 1,   32'h00};
        tbl[11] = '{1, 0, 32'h00, 1, 32'h10, 1,   32'h04};
        tbl[12] = '{1, 1, 32'h10, 1, 32'h14, 1,   32'h08};
        tbl[13] = '{1, 1, 32'h14, 1, 32'h18, 1,   32'h0C};
        tbl[14] = '{1, 1, 32'h18, 1, 32'h1C, 1,   32'h10};
        tbl[15] = '{1, 1, 32'h1C, 1, 32'h20, 1,   32'h14};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            imem_req_ready = 1'b1;
            redirect_valid = 1'b0;
            id_ready       = tbl[i].idr;
            imem_rsp_valid = tbl[i].rspv;
            imem_rsp_data  = mem_word(tbl[i].rsp_addr);
            @(negedge clk);
            chk($sformatf("vec%0d_req_valid", i), imem_req_valid, tbl[i].e_req);
            chk($sformatf("vec%0d_req_addr", i),  imem_req_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_if_valid", i),  if_valid, tbl[i].e_ifv);
            if (tbl[i].e_ifv) begin
                chk($sformatf("vec%0d_if_pc", i),   if_pc, tbl[i].e_pc);
                chk($sformatf("vec%0d_if_inst", i), if_inst, mem_word(tbl[i].e_pc));
            end else begin
                chk($sformatf("vec%0d_if_inst", i), if_inst, NOP);
            end
            @(posedge clk); #1;
        end

        // Redirect to an unaligned target with two requests in flight.
        do_reset();
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        chk("two_outstanding", pend.size(), 2);
        step(1, 0, 1, 1, 32'h0000_0103);
        wait_consumes(1, "redirect_first_decode");

        // Redirect coinciding with a response.
        do_reset();
        step(1, 0, 1, 0, '0);
        step(1, 0, 1, 0, '0);
        step(1, 1, 1, 1, 32'h0000_0040);
        wait_consumes(3, "redirect_with_rsp_decode");

        // Fetch stream wrapping past the top of the address space.
        step(1, 1, 1, 1, 32'hFFFF_FFF8);
        wait_consumes(3, "wrap_decode");

        // Reset asserted while flushing with one request in flight.
        do_reset();
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 1, 32'h0000_0200);
        chk("flush_addr_before_reset", imem_req_addr, 32'h0000_0200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_valid", imem_req_valid, 0);
        chk("async_rst_req_addr",  imem_req_addr, RESET_PC);
        chk("async_rst_if_valid",  if_valid, 0);
        chk("async_rst_if_pc",     if_pc, 0);
        chk("async_rst_if_inst",   if_inst, NOP);
        do_reset();
        step(1, 0, 1, 0, '0);
        chk("post_reset_first_req", pend.size(), 1);

        // Response-to-decode latency with an empty FIFO.
        step(1, 1, 1, 0, '0);
        chk("rsp_to_if_latency", last_ifv, BYP);
        step(1, 1, 1, 0, '0);
        chk("rsp_to_if_next_cycle", last_ifv, 1);

        // Randomized traffic with occasional redirects.
        do_reset();
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
                 ($urandom % 40) == 0, $urandom);
        end
        chk("random_progress", (consumed - c0) > 200, 1);
        wait_consumes(4, "final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
